ssd_bcd_scanner: RTL and testbench
==================================

# ssd_bcd_scanner

Parametrised seven-segment display driver for the Nexys4 8-digit display, replacing the fixed 4-digit counter/anode path in the game top level. It sequentially converts a binary value such as the zombies-killed score to BCD using shift-add-3. It then time-multiplexes up to 8 digits with leading-zero blanking, overflow dashes and per-digit decimal points. The driver owns all anodes, so no upper anodes are left undriven.

## Interface
- DIGITS, 8, number of digits scanned (1..8)
- VALUE_W, 27, binary input width (4..32)
- REFRESH_DIV, 100000, clk cycles each digit is held (≥1; default gives 1 kHz per digit at 100 MHz)
- clk  in  1  system clock (ClkPort at top)
- reset  in  1  asynchronous, active-high reset
- value  in  VALUE_W  unsigned number to display
- load  in  1  request sampling of value and conversion; honoured only when busy=0
- dp_mask  in  DIGITS  1 = light decimal point of digit i; sampled live
- busy  out  1  conversion in progress
- overflow  out  1  last committed value ≥ 10^DIGITS
- anode  out  DIGITS  active-low one-hot digit enable, bit 0 = rightmost
- seg  out  7  active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg}
- dp  out  1  active-low decimal point

## Operation
- Converter FSM has two states: IDLE and CONV.
- IDLE + load: capture value into the shift register, clear the BCD work register (4*DIGITS bits) and the sticky overflow flag, set iter=0, go to CONV.
- CONV, each cycle: add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1. If the BCD MSB shifted out is 1, set sticky overflow.
- After the VALUE_W-th shift, commit the BCD work register to the display register and sticky overflow to the overflow output, drop busy, and return to IDLE.
- load while busy=0 is accepted. load while busy=1 is dropped and not queued.
- The display register changes only at commit. The old digits stay visible throughout a conversion.
- Scanner: prescaler counts 0..REFRESH_DIV-1. On wrap, the digit index advances by 1, wrapping DIGITS-1 → 0. The scanner runs independently of the converter.
- Per-digit segment source, in priority order:
  - overflow=1: dash 1111110 on every digit.
  - Digit i>0 with all committed digits ≥i equal to zero: blank 1111111.
  - Otherwise, decode the nibble: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Digit 0 is never blanked, so value 0 shows "0".
- dp = ~dp_mask[index]. The dp_mask is not suppressed by blanking or overflow.
- The anode for a blanked digit is still driven low, which keeps brightness timing uniform.

## Timing
- All outputs are registered.
- Reset values:
  - anode all 1, seg 1111111, dp 1, busy 0, overflow 0.
  - Display register 0, index 0, prescaler 0, FSM IDLE.
- First clock edge after reset release: anode = ~1 (digit 0), seg shows "0".
- Load accepted at edge E0 sets busy=1. Shifts occur at E1..E_VALUE_W. Commit and busy=0 happen at E_VALUE_W, so busy is high for exactly VALUE_W cycles.
- seg and overflow reflect the new value from edge E_VALUE_W+1 onward (one output register stage).
- load asserted in the same cycle busy falls is ignored, because busy is still 1 in that cycle.
- Each anode is low for exactly REFRESH_DIV cycles. The full frame is DIGITS*REFRESH_DIV cycles.
- Index and segment change on the same edge, with no ghosting cycle.
- With REFRESH_DIV=1, the index advances every cycle.
- Reset asserted mid-conversion: immediate abort to the reset values. The partial result is never committed.
- Values ≥ 10^DIGITS, including the all-ones input, set overflow. 10^DIGITS-1 does not.

## Test plan
Bench parameters: DIGITS=4, VALUE_W=16, REFRESH_DIV=4.
- Reset then release: anode=1111 during reset, then 1110, seg=0000001. Digits 1-3 show seg=1111111. Each anode is held 4 cycles, and the sequence 1110,1101,1011,0111 repeats.
- load value=1234: busy high exactly 16 cycles. Then digit0 seg=1001100, digit1 0000110, digit2 0010010, digit3 1001111, overflow=0.
- load 9999 → four digits of 0000100, overflow=0. Then load 10000 → overflow=1, all digits 1111110. Then load 65535 → overflow=1.
- load 42, then load 7 two cycles later: the second load is ignored, the display shows "42" after 16 cycles, and digits 2-3 are blank.
- load 5 with dp_mask=0010 → digit0 seg=0100100, digits 1-3 blank, dp=0 only while anode=1101. Then load 0 → digit0 0000001.
- load 1234, then assert reset at cycle 8 of busy: all outputs return to reset values, busy=0. After release the display shows "0", and 1234 never appears.

Source files
------------

// File: rtl/ssd_bcd_scanner.sv
// ssd_bcd_scanner: serial binary-to-BCD converter feeding a multiplexed seven-segment scanner
module ssd_bcd_scanner #(
  parameter int DIGITS      = 8,
  parameter int VALUE_W     = 27,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic [DIGITS-1:0]  dp_mask,
  output logic               busy,
  output logic               overflow,
  output logic [DIGITS-1:0]  anode,
  output logic [6:0]         seg,
  output logic               dp
);
  localparam int BW = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int CW = $clog2(VALUE_W);
  typedef enum logic {IDLE, CONV} state_t;
  state_t             state;
  logic [VALUE_W-1:0] bin;
  logic [BW-1:0]      bcd, adj, disp, bcd_n;
  logic [CW-1:0]      iter;
  logic               sticky, ovf_c, ovf_n;
  logic [PW-1:0]      presc;
  logic [IW-1:0]      idx;
  logic [3:0]         nib;
  logic               blank, wrap;
  logic [6:0]         seg_n;
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0:    dec = 7'b0000001;
      4'd1:    dec = 7'b1001111;
      4'd2:    dec = 7'b0010010;
      4'd3:    dec = 7'b0000110;
      4'd4:    dec = 7'b1001100;
      4'd5:    dec = 7'b0100100;
      4'd6:    dec = 7'b0100000;
      4'd7:    dec = 7'b0001111;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0000100;
      default: dec = 7'b1111110;
    endcase
  endfunction
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end
  // A one leaving the top nibble means the prefix already reached 10^DIGITS
  assign bcd_n = {adj[BW-2:0], bin[VALUE_W-1]};
  assign ovf_n = sticky | adj[BW-1];
  assign wrap  = presc == PW'(REFRESH_DIV - 1);
  assign nib   = disp[{idx, 2'b00} +: 4];
  assign blank = (idx != '0) && ((disp >> {idx, 2'b00}) == '0);
  assign seg_n = ovf_c ? 7'b1111110 : blank ? 7'b1111111 : dec(nib);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bin      <= '0;
      bcd      <= '0;
      iter     <= '0;
      sticky   <= 1'b0;
      disp     <= '0;
      ovf_c    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      presc    <= '0;
      idx      <= '0;
      anode    <= '1;
      seg      <= 7'b1111111;
      dp       <= 1'b1;
    end else begin
      presc    <= wrap ? '0 : presc + 1'b1;
      idx      <= !wrap ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      anode    <= ~(DIGITS'(1) << idx);
      seg      <= seg_n;
      dp       <= ~dp_mask[idx];
      overflow <= ovf_c;
      if (state == IDLE) begin
        if (load) begin
          bin    <= value;
          bcd    <= '0;
          sticky <= 1'b0;
          iter   <= '0;
          busy   <= 1'b1;
          state  <= CONV;
        end
      end else begin
        bcd    <= bcd_n;
        bin    <= bin << 1;
        sticky <= ovf_n;
        iter   <= iter + 1'b1;
        if (iter == CW'(VALUE_W - 1)) begin
          disp  <= bcd_n;
          ovf_c <= ovf_n;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_ssd_bcd_scanner.sv
// tb_ssd_bcd_scanner: directed checks of conversion, blanking, overflow, dp and scan timing
module tb_ssd_bcd_scanner;
  logic        clk = 1'b0, reset = 1'b1, load = 1'b0, busy, overflow, dp;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0, anode;
  logic [6:0]  seg;
  logic [6:0]  cap_seg [4];
  logic        cap_dp [4];
  int          n_chk = 0, n_fail = 0;
  localparam logic [6:0] BLK = 7'b1111111, DSH = 7'b1111110;
  ssd_bcd_scanner #(.DIGITS(4), .VALUE_W(16), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .dp_mask(dp_mask),
    .busy(busy), .overflow(overflow), .anode(anode), .seg(seg), .dp(dp)
  );
  always #5 clk = ~clk;
  task automatic capture;
    for (int i = 0; i < 4; i++) begin
      cap_seg[i] = 'x;
      cap_dp[i]  = 1'bx;
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (anode == ~(4'b1 << i)) begin
          cap_seg[i] = seg;
          cap_dp[i]  = dp;
        end
    end
  endtask
  task automatic start_load(input logic [15:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask
  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
  endtask
  task automatic test_reset;
    logic [3:0] ea;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({anode, seg, dp, busy, overflow} !== {4'b1111, BLK, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_vals: got anode=%b seg=%b dp=%b busy=%b ovf=%b", anode, seg, dp, busy, overflow);
    end
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      ea = ~(4'b1 << ((k - 1) / 4));
      n_chk++;
      if (anode !== ea) begin
        n_fail++;
        $display("FAIL scan_seq k=%0d: got %b want %b", k, anode, ea);
      end
      if (k == 1) begin
        n_chk++;
        if (seg !== 7'b0000001) begin
          n_fail++;
          $display("FAIL first_seg: got %b want 0000001", seg);
        end
      end
    end
    capture();
    for (int i = 1; i < 4; i++) begin
      n_chk++;
      if (cap_seg[i] !== BLK || cap_dp[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_blank d%0d: got seg=%b dp=%b want %b 1", i, cap_seg[i], cap_dp[i], BLK);
      end
    end
  endtask
  task automatic test_value(input logic [15:0] v, input logic [6:0] e3, e2, e1, e0, input logic eo);
    int n;
    logic [6:0] es [4];
    es = '{e0, e1, e2, e3};
    start_load(v);
    wait_busy(n);
    n_chk++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL busy_len v=%0d: got %0d want 16", v, n);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (overflow !== eo) begin
      n_fail++;
      $display("FAIL overflow v=%0d: got %b want %b", v, overflow, eo);
    end
    capture();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (cap_seg[i] !== es[i]) begin
        n_fail++;
        $display("FAIL digit v=%0d d%0d: got %b want %b", v, i, cap_seg[i], es[i]);
      end
    end
  endtask
  task automatic test_back_to_back;
    int n;
    start_load(16'd42);
    @(posedge clk);
    #1 value = 16'd7;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    wait_busy(n);
    n_chk++;
    if (n !== 14) begin
      n_fail++;
      $display("FAIL b2b_busy: got %0d remaining want 14", n);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_queued: busy got %b want 0", busy);
    end
    capture();
    n_chk++;
    if ({cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]} !== {BLK, BLK, 7'b1001100, 7'b0010010}) begin
      n_fail++;
      $display("FAIL b2b_digits: got %b %b %b %b want 42", cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]);
    end
  endtask
  task automatic test_dp;
    dp_mask = 4'b0010;
    test_value(16'd5, BLK, BLK, BLK, 7'b0100100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (cap_dp[i] !== (i != 1)) begin
        n_fail++;
        $display("FAIL dp d%0d: got %b want %b", i, cap_dp[i], i != 1);
      end
    end
    dp_mask = 4'b0000;
    test_value(16'd0, BLK, BLK, BLK, 7'b0000001, 1'b0);
  endtask
  task automatic test_reset_mid;
    start_load(16'd1234);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_chk++;
    if ({anode, seg, dp, busy, overflow} !== {4'b1111, BLK, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: got anode=%b seg=%b dp=%b busy=%b ovf=%b", anode, seg, dp, busy, overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_idle: busy=%b ovf=%b want 0 0", busy, overflow);
    end
    capture();
    n_chk++;
    if ({cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]} !== {BLK, BLK, BLK, 7'b0000001}) begin
      n_fail++;
      $display("FAIL mid_digits: got %b %b %b %b want blank x3 then 0", cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]);
    end
  endtask
  initial begin
    test_reset();
    test_value(16'd1234, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 1'b0);
    test_value(16'd9999, 7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100, 1'b0);
    test_value(16'd10000, DSH, DSH, DSH, DSH, 1'b1);
    test_value(16'd65535, DSH, DSH, DSH, DSH, 1'b1);
    test_back_to_back();
    test_reset_mid();
    test_dp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
